// File: rtl/multi_lane_pipe_regs_pkg.sv
// Shared defaults and helpers for the multi-lane inter-stage register chain:
// the branch lane-kill mask and the forwarding priority select.
package pipe_pkg;

   localparam int DEF_LANES     = 2;
   localparam int DEF_STAGES    = 2;
   localparam int DEF_PC_W      = 32;
   localparam int DEF_DATA_W    = 32;
   localparam int DEF_ADDR_W    = 5;
   localparam int DEF_UPD_STAGE = 0;
   localparam int DEF_RD_PORTS  = 4;

   localparam int MAX_LANES  = 16;
   localparam int MAX_STAGES = 8;
   localparam int MAX_ENT    = MAX_LANES * MAX_STAGES;

   // Surviving lanes: everything up to and including the redirecting lane.
   function automatic logic [MAX_LANES-1:0] kill_mask(input logic br_redirect,
                                                      input int   br_lane,
                                                      input int   lanes);
      kill_mask = '0;
      for (int i = 0; i < MAX_LANES; i++)
         kill_mask[i] = (i < lanes) && (!br_redirect || i <= br_lane);
   endfunction

   // Entry index is rank*lanes+lane. Youngest rank wins, then the higher lane;
   // the loop order makes the last assignment the winner. -1 means no match.
   function automatic int fwd_sel(input logic [MAX_ENT-1:0] match,
                                  input int lanes,
                                  input int stages);
      fwd_sel = -1;
      for (int r = MAX_STAGES-1; r >= 0; r--)
         for (int l = 0; l < MAX_LANES; l++)
            if (r < stages && l < lanes && match[r*lanes+l])
               fwd_sel = r*lanes + l;
   endfunction

endpackage

// File: rtl/multi_lane_pipe_regs_if.sv
// Bus bundle for the register chain: bundle entry, control, rank taps and
// forwarding lookup ports.
interface multi_lane_pipe_regs_if #(
   parameter int LANES    = 2,
   parameter int STAGES   = 2,
   parameter int PC_W     = 32,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int RD_PORTS = 4
);
   localparam int BRL_W = (LANES > 1) ? $clog2(LANES) : 1;

   logic                                      stall;
   logic                                      flush;
   logic [LANES-1:0]                          in_valid;
   logic [LANES-1:0][PC_W-1:0]                in_pc;
   logic [LANES-1:0]                          in_we;
   logic [LANES-1:0][ADDR_W-1:0]              in_waddr;
   logic [LANES-1:0][DATA_W-1:0]              in_wdata;
   logic                                      br_redirect;
   logic [BRL_W-1:0]                          br_lane;
   logic [LANES-1:0]                          upd_en;
   logic [LANES-1:0][DATA_W-1:0]              upd_wdata;
   logic [STAGES-1:0][LANES-1:0]              stg_valid;
   logic [STAGES-1:0][LANES-1:0][PC_W-1:0]    stg_pc;
   logic [STAGES-1:0][LANES-1:0]              stg_we;
   logic [STAGES-1:0][LANES-1:0][ADDR_W-1:0]  stg_waddr;
   logic [STAGES-1:0][LANES-1:0][DATA_W-1:0]  stg_wdata;
   logic [RD_PORTS-1:0][ADDR_W-1:0]           fwd_raddr;
   logic [RD_PORTS-1:0]                       fwd_hit;
   logic [RD_PORTS-1:0][DATA_W-1:0]           fwd_data;

   modport master (
      output stall, flush, in_valid, in_pc, in_we, in_waddr, in_wdata,
             br_redirect, br_lane, upd_en, upd_wdata, fwd_raddr,
      input  stg_valid, stg_pc, stg_we, stg_waddr, stg_wdata, fwd_hit, fwd_data
   );

   modport slave (
      input  stall, flush, in_valid, in_pc, in_we, in_waddr, in_wdata,
             br_redirect, br_lane, upd_en, upd_wdata, fwd_raddr,
      output stg_valid, stg_pc, stg_we, stg_waddr, stg_wdata, fwd_hit, fwd_data
   );
endinterface

// File: rtl/multi_lane_pipe_regs_rank.sv
// One register rank of LANES entries: async reset, sync clear, hold,
// per-lane kill (zero everything) and per-lane wdata override.
module pipe_rank #(
   parameter int LANES  = 2,
   parameter int PC_W   = 32,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            clr_i,
   input  logic                            hold_i,
   input  logic [LANES-1:0]                keep_i,
   input  logic [LANES-1:0]                valid_i,
   input  logic [LANES-1:0]                we_i,
   input  logic [LANES-1:0][PC_W-1:0]      pc_i,
   input  logic [LANES-1:0][ADDR_W-1:0]    waddr_i,
   input  logic [LANES-1:0][DATA_W-1:0]    wdata_i,
   input  logic [LANES-1:0]                upd_en_i,
   input  logic [LANES-1:0][DATA_W-1:0]    upd_wdata_i,
   output logic [LANES-1:0]                valid_o,
   output logic [LANES-1:0]                we_o,
   output logic [LANES-1:0][PC_W-1:0]      pc_o,
   output logic [LANES-1:0][ADDR_W-1:0]    waddr_o,
   output logic [LANES-1:0][DATA_W-1:0]    wdata_o
);
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic              valid_q, valid_d, we_q, we_d;
      logic [PC_W-1:0]   pc_q, pc_d;
      logic [ADDR_W-1:0] waddr_q, waddr_d;
      logic [DATA_W-1:0] wdata_q, wdata_d;

      // Clear beats hold, so a flush lands even while stalled.
      always_comb begin
         valid_d = valid_q;
         we_d    = we_q;
         pc_d    = pc_q;
         waddr_d = waddr_q;
         wdata_d = wdata_q;
         if (clr_i || (!hold_i && !keep_i[i])) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
            pc_d    = '0;
            waddr_d = '0;
            wdata_d = '0;
         end else if (!hold_i) begin
            valid_d = valid_i[i];
            we_d    = we_i[i];
            pc_d    = pc_i[i];
            waddr_d = waddr_i[i];
            wdata_d = upd_en_i[i] ? upd_wdata_i[i] : wdata_i[i];
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            pc_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
         end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            pc_q    <= pc_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
         end
      end

      assign valid_o[i] = valid_q;
      assign we_o[i]    = we_q;
      assign pc_o[i]    = pc_q;
      assign waddr_o[i] = waddr_q;
      assign wdata_o[i] = wdata_q;
   end
endmodule

// File: rtl/multi_lane_pipe_regs.sv
// Multi-issue inter-stage register chain: STAGES ranks of LANES slots with
// branch kill on entry, mid-chain wdata replacement and forwarding lookup.
module multi_lane_pipe_regs
   import pipe_pkg::*;
#(
   parameter int LANES     = DEF_LANES,
   parameter int STAGES    = DEF_STAGES,
   parameter int PC_W      = DEF_PC_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int UPD_STAGE = DEF_UPD_STAGE,
   parameter int RD_PORTS  = DEF_RD_PORTS
) (
   input  logic                  clk,
   input  logic                  rst,
   multi_lane_pipe_regs_if.slave bus
);
   localparam int BRL_W = (LANES > 1) ? $clog2(LANES) : 1;

   logic [STAGES-1:0][LANES-1:0]              stg_valid, stg_we;
   logic [STAGES-1:0][LANES-1:0][PC_W-1:0]    stg_pc;
   logic [STAGES-1:0][LANES-1:0][ADDR_W-1:0]  stg_waddr;
   logic [STAGES-1:0][LANES-1:0][DATA_W-1:0]  stg_wdata;

   logic [STAGES-1:0][LANES-1:0]              r_valid, r_we, r_keep, r_upd;
   logic [STAGES-1:0][LANES-1:0][PC_W-1:0]    r_pc;
   logic [STAGES-1:0][LANES-1:0][ADDR_W-1:0]  r_waddr;
   logic [STAGES-1:0][LANES-1:0][DATA_W-1:0]  r_wdata;

   logic [MAX_LANES-1:0] keep_all;
   logic                 unused_keep;
   int                   brl;

   assign brl         = {{(32-BRL_W){1'b0}}, bus.br_lane};
   assign keep_all    = kill_mask(bus.br_redirect, brl, LANES);
   assign unused_keep = ^keep_all;

   for (genvar s = 0; s < STAGES; s++) begin : g_rank
      if (s == 0) begin : g_entry
         assign r_valid[s] = bus.in_valid;
         assign r_we[s]    = bus.in_we & bus.in_valid;
         assign r_pc[s]    = bus.in_pc;
         assign r_waddr[s] = bus.in_waddr;
         assign r_wdata[s] = bus.in_wdata;
         assign r_keep[s]  = keep_all[LANES-1:0];
      end else begin : g_chain
         assign r_valid[s] = stg_valid[s-1];
         assign r_we[s]    = stg_we[s-1];
         assign r_pc[s]    = stg_pc[s-1];
         assign r_waddr[s] = stg_waddr[s-1];
         assign r_wdata[s] = stg_wdata[s-1];
         assign r_keep[s]  = '1;
      end
      assign r_upd[s] = (s == UPD_STAGE + 1) ? bus.upd_en : '0;

      pipe_rank #(.LANES(LANES), .PC_W(PC_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rank (
         .clk        (clk),
         .rst        (rst),
         .clr_i      (bus.flush),
         .hold_i     (bus.stall),
         .keep_i     (r_keep[s]),
         .valid_i    (r_valid[s]),
         .we_i       (r_we[s]),
         .pc_i       (r_pc[s]),
         .waddr_i    (r_waddr[s]),
         .wdata_i    (r_wdata[s]),
         .upd_en_i   (r_upd[s]),
         .upd_wdata_i(bus.upd_wdata),
         .valid_o    (stg_valid[s]),
         .we_o       (stg_we[s]),
         .pc_o       (stg_pc[s]),
         .waddr_o    (stg_waddr[s]),
         .wdata_o    (stg_wdata[s])
      );
   end

   assign bus.stg_valid = stg_valid;
   assign bus.stg_we    = stg_we;
   assign bus.stg_pc    = stg_pc;
   assign bus.stg_waddr = stg_waddr;
   assign bus.stg_wdata = stg_wdata;

   // Lookup sees registered state only; r0 is never a real writer.
   for (genvar p = 0; p < RD_PORTS; p++) begin : g_fwd
      logic [MAX_ENT-1:0] match;
      int                 sel;
      logic               hit;
      logic [DATA_W-1:0]  data;

      always_comb begin
         match = '0;
         for (int r = 0; r < STAGES; r++)
            for (int l = 0; l < LANES; l++)
               match[r*LANES+l] = stg_valid[r][l] & stg_we[r][l] &
                                  (stg_waddr[r][l] == bus.fwd_raddr[p]) &
                                  (bus.fwd_raddr[p] != '0);
         sel  = fwd_sel(match, LANES, STAGES);
         hit  = (sel >= 0);
         data = '0;
         for (int r = 0; r < STAGES; r++)
            for (int l = 0; l < LANES; l++)
               if (sel == r*LANES + l) data = stg_wdata[r][l];
      end

      assign bus.fwd_hit[p]  = hit;
      assign bus.fwd_data[p] = data;
   end
endmodule

// File: tb/tb_multi_lane_pipe_regs.sv
// Directed + randomised bench: a queue holds the expected rank contents,
// pushed on entry and retired out of the last rank.
module tb_multi_lane_pipe_regs;
   localparam int L = 4, S = 2, PW = 32, DW = 32, AW = 5, RP = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   multi_lane_pipe_regs_if #(.LANES(L), .STAGES(S), .PC_W(PW), .DATA_W(DW),
                             .ADDR_W(AW), .RD_PORTS(RP)) bus ();

   multi_lane_pipe_regs #(.LANES(L), .STAGES(S), .PC_W(PW), .DATA_W(DW),
                          .ADDR_W(AW), .UPD_STAGE(0), .RD_PORTS(RP)) dut (
      .clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [L-1:0]         v, we;
      logic [L-1:0][PW-1:0] pc;
      logic [L-1:0][AW-1:0] wa;
      logic [L-1:0][DW-1:0] wd;
   } ent_t;

   ent_t pipeq[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic ent_t zero_ent();
      ent_t e;
      e.v = '0; e.we = '0; e.pc = '0; e.wa = '0; e.wd = '0;
      return e;
   endfunction

   function automatic void model_reset();
      pipeq.delete();
      pipeq.push_back(zero_ent());
      pipeq.push_back(zero_ent());
   endfunction

   function automatic void apply_edge();
      ent_t n, r1;
      if (bus.flush) begin model_reset(); return; end
      if (bus.stall) return;
      r1 = pipeq[0];
      for (int l = 0; l < L; l++)
         if (bus.upd_en[l]) r1.wd[l] = bus.upd_wdata[l];
      n = zero_ent();
      for (int l = 0; l < L; l++)
         if (!bus.br_redirect || l <= int'(bus.br_lane)) begin
            n.v[l]  = bus.in_valid[l];
            n.we[l] = bus.in_valid[l] & bus.in_we[l];
            n.pc[l] = bus.in_pc[l];
            n.wa[l] = bus.in_waddr[l];
            n.wd[l] = bus.in_wdata[l];
         end
      void'(pipeq.pop_back());
      pipeq[0] = r1;
      pipeq.push_front(n);
   endfunction

   function automatic void fwd_model(input logic [AW-1:0] ra, output logic hit,
                                     output logic [DW-1:0] d);
      hit = 1'b0; d = '0;
      if (ra != '0)
         for (int r = 0; r < S; r++)
            for (int l = L-1; l >= 0; l--)
               if (!hit && pipeq[r].v[l] && pipeq[r].we[l] && pipeq[r].wa[l] == ra) begin
                  hit = 1'b1; d = pipeq[r].wd[l];
               end
   endfunction

   task automatic check_all(input string tag);
      logic h; logic [DW-1:0] d;
      for (int r = 0; r < S; r++) begin
         chk($sformatf("%s_r%0d_valid", tag, r), bus.stg_valid[r], pipeq[r].v);
         chk($sformatf("%s_r%0d_we",    tag, r), bus.stg_we[r],    pipeq[r].we);
         chk($sformatf("%s_r%0d_pc",    tag, r), bus.stg_pc[r],    pipeq[r].pc);
         chk($sformatf("%s_r%0d_waddr", tag, r), bus.stg_waddr[r], pipeq[r].wa);
         chk($sformatf("%s_r%0d_wdata", tag, r), bus.stg_wdata[r], pipeq[r].wd);
      end
      for (int p = 0; p < RP; p++) begin
         fwd_model(bus.fwd_raddr[p], h, d);
         chk($sformatf("%s_fwd%0d_hit",  tag, p), bus.fwd_hit[p],  h);
         chk($sformatf("%s_fwd%0d_data", tag, p), bus.fwd_data[p], d);
      end
   endtask

   task automatic adv(input string tag);
      @(posedge clk);
      apply_edge();
      #1;
      check_all(tag);
   endtask

   task automatic idle();
      bus.stall = 0; bus.flush = 0; bus.br_redirect = 0; bus.br_lane = '0;
      bus.in_valid = '0; bus.in_we = '0; bus.in_pc = '0; bus.in_waddr = '0;
      bus.in_wdata = '0; bus.upd_en = '0; bus.upd_wdata = '0;
   endtask

   task automatic rand_inputs();
      for (int i = 0; i < L; i++) begin
         bus.in_pc[i]     = $urandom();
         bus.in_waddr[i]  = AW'($urandom_range(0, 7));
         bus.in_wdata[i]  = $urandom();
         bus.upd_wdata[i] = $urandom();
      end
      bus.in_valid    = L'($urandom());
      bus.in_we       = L'($urandom());
      bus.upd_en      = L'($urandom());
      bus.br_redirect = ($urandom_range(0, 3) == 0);
      bus.br_lane     = 2'($urandom_range(0, L-1));
   endtask

   initial begin
      logic [L-1:0][DW-1:0] snap_wd;
      logic [L-1:0]         snap_v;

      idle();
      bus.fwd_raddr = '0;
      model_reset();
      #1;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // Basic advance through both ranks
      bus.in_valid = 4'b0001; bus.in_we = 4'b0001;
      bus.in_pc[0] = 32'h1000; bus.in_waddr[0] = 5'd3; bus.in_wdata[0] = 32'hAA;
      bus.fwd_raddr[3] = 5'd3;
      adv("adv0");
      idle();
      adv("adv1");
      chk("adv_r1_valid0", bus.stg_valid[1][0], 1'b1);
      chk("adv_r1_pc0",    bus.stg_pc[1][0],    32'h1000);
      chk("adv_r1_we0",    bus.stg_we[1][0],    1'b1);
      chk("adv_r1_waddr0", bus.stg_waddr[1][0], 5'd3);
      chk("adv_r1_wdata0", bus.stg_wdata[1][0], 32'hAA);
      chk("adv_fwd_r3",    bus.fwd_data[3],     32'hAA);

      // Branch kill of lanes younger than lane 1
      bus.in_valid = '1; bus.in_we = '1;
      for (int i = 0; i < L; i++) begin
         bus.in_pc[i] = 32'h2000 + 32'(4*i);
         bus.in_waddr[i] = AW'(8 + i);
         bus.in_wdata[i] = 32'h100 + 32'(i);
      end
      bus.br_redirect = 1'b1; bus.br_lane = 2'd1;
      adv("kill");
      chk("kill_valid", bus.stg_valid[0],    4'b0011);
      chk("kill_we",    bus.stg_we[0],       4'b0011);
      chk("kill_pc1",   bus.stg_pc[0][1],    32'h2004);
      chk("kill_pc2",   bus.stg_pc[0][2],    32'h0);
      chk("kill_wa3",   bus.stg_waddr[0][3], 5'h0);
      chk("kill_wd3",   bus.stg_wdata[0][3], 32'h0);
      bus.br_redirect = 1'b0;

      // Invalid lanes never write
      bus.in_valid = 4'b0101; bus.in_we = '1;
      adv("inval");
      chk("inval_we", bus.stg_we[0], 4'b0101);

      // Stall holds every rank (upd_en included), then flush wins over stall
      snap_wd = bus.stg_wdata[1];
      snap_v  = bus.stg_valid[0];
      bus.stall = 1'b1;
      repeat (3) begin rand_inputs(); adv("stall"); end
      chk("stall_hold_wd1", bus.stg_wdata[1], snap_wd);
      chk("stall_hold_v0",  bus.stg_valid[0], snap_v);
      bus.flush = 1'b1;
      adv("flush");
      chk("flush_valid", bus.stg_valid, 8'h00);
      idle();

      // Mid-chain replacement of lane 1 only
      bus.in_valid = 4'b0011; bus.in_we = 4'b0011;
      bus.in_waddr[0] = 5'd1; bus.in_wdata[0] = 32'h22;
      bus.in_waddr[1] = 5'd2; bus.in_wdata[1] = 32'h11;
      adv("upd0");
      idle();
      bus.upd_en = 4'b0010; bus.upd_wdata[1] = 32'h55; bus.upd_wdata[0] = 32'h77;
      adv("upd1");
      chk("upd_lane1",  bus.stg_wdata[1][1], 32'h55);
      chk("upd_lane0",  bus.stg_wdata[1][0], 32'h22);
      chk("upd_valid",  bus.stg_valid[1],    4'b0011);
      idle();

      // Forwarding priority
      bus.fwd_raddr[0] = 5'd5; bus.fwd_raddr[1] = 5'd0;
      bus.fwd_raddr[2] = 5'd9; bus.fwd_raddr[3] = 5'd3;
      bus.in_valid = 4'b0101; bus.in_we = 4'b0101;
      bus.in_waddr[0] = 5'd5; bus.in_wdata[0] = 32'h1;
      bus.in_waddr[2] = 5'd0; bus.in_wdata[2] = 32'hDEAD;
      adv("fwdA");
      idle();
      bus.in_valid = 4'b0001; bus.in_we = 4'b0001;
      bus.in_waddr[0] = 5'd5; bus.in_wdata[0] = 32'h2;
      adv("fwdB");
      chk("fwd_young_hit",  bus.fwd_hit[0],  1'b1);
      chk("fwd_young_data", bus.fwd_data[0], 32'h2);
      chk("fwd_r0_hit",     bus.fwd_hit[1],  1'b0);
      chk("fwd_r0_data",    bus.fwd_data[1], 32'h0);
      chk("fwd_miss_hit",   bus.fwd_hit[2],  1'b0);
      idle();
      bus.in_valid = 4'b0001; bus.in_we = 4'b0001;
      bus.in_waddr[0] = 5'd5; bus.in_wdata[0] = 32'h1;
      adv("fwdC");
      bus.in_valid = 4'b0011; bus.in_we = 4'b0011;
      bus.in_waddr[1] = 5'd5; bus.in_wdata[0] = 32'h2; bus.in_wdata[1] = 32'h3;
      adv("fwdD");
      chk("fwd_lane_data", bus.fwd_data[0], 32'h3);
      // Unregistered inputs must not be visible to the lookup
      bus.stall = 1'b1;
      bus.in_valid = 4'b1000; bus.in_we = 4'b1000;
      bus.in_waddr[3] = 5'd5; bus.in_wdata[3] = 32'h99;
      #1;
      chk("fwd_no_bypass", bus.fwd_data[0], 32'h3);
      idle();

      // Random stream
      repeat (40) begin
         rand_inputs();
         bus.stall = ($urandom_range(0, 3) == 0);
         bus.flush = ($urandom_range(0, 7) == 0);
         for (int p = 0; p < RP; p++) bus.fwd_raddr[p] = AW'($urandom_range(0, 7));
         adv("rnd");
      end
      idle();

      // Asynchronous reset between edges
      rand_inputs();
      bus.in_valid = '1; bus.in_we = '1; bus.br_redirect = 1'b0; bus.upd_en = '0;
      adv("pre_rst");
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_all("async_rst");
      chk("async_rst_valid", bus.stg_valid, 8'h00);
      @(posedge clk);
      #1;
      check_all("rst_hold");
      @(negedge clk);
      rst = 1'b0;
      adv("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/multi_lane_pipe_regs.md
# multi_lane_pipe_regs

Parametrised inter-stage register chain for the multi-issue back end, carrying LANES issue slots through STAGES register ranks (default: EX→MEM, MEM→WB). It carries per-lane valid, PC and register-writeback fields. It supports global stall and flush, and kills lanes younger than a redirecting branch on entry. Mid-chain result replacement lets a later stage substitute load or multiply results. Register-file forwarding lookup is combinational over all in-flight entries.

## Interface
Parameters:
- LANES, 2, issue slots per stage; lane 0 is the oldest.
- STAGES, 2, register ranks; rank 0 is captured from the inputs.
- PC_W, 32, PC width.
- DATA_W, 32, writeback data width.
- ADDR_W, 5, register address width.
- UPD_STAGE, 0, rank whose wdata may be replaced on transfer to rank UPD_STAGE+1; must be < STAGES-1.
- RD_PORTS, 4, forwarding lookup ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- stall  in  1  holds every rank.
- flush  in  1  synchronous clear of every rank; has priority over stall.
- in_valid  in  LANES  lane carries an instruction.
- in_pc  in  LANES×PC_W  lane PC.
- in_we  in  LANES  register write enable.
- in_waddr  in  LANES×ADDR_W  destination register.
- in_wdata  in  LANES×DATA_W  ALU result.
- br_redirect  in  1  a lane in the entering bundle mispredicted.
- br_lane  in  $clog2(LANES)  index of the redirecting lane.
- upd_en  in  LANES  replace wdata of this lane at rank UPD_STAGE.
- upd_wdata  in  LANES×DATA_W  replacement data.
- stg_valid  out  STAGES×LANES  per-rank, per-lane valid.
- stg_pc  out  STAGES×LANES×PC_W.
- stg_we  out  STAGES×LANES.
- stg_waddr  out  STAGES×LANES×ADDR_W.
- stg_wdata  out  STAGES×LANES×DATA_W.
- fwd_raddr  in  RD_PORTS×ADDR_W  lookup address.
- fwd_hit  out  RD_PORTS  a valid in-flight writer exists.
- fwd_data  out  RD_PORTS×DATA_W  data of the youngest matching writer; 0 on miss.

## Operation
- Reset and flush: every rank's valid, pc, we, waddr and wdata go to 0. Consequently fwd_hit=0 and fwd_data=0.
- Advance (no rst, no flush, no stall):
  - Rank 0 captures the inputs.
  - Rank k captures rank k-1 for k ≥ 1.
- Stall: all ranks hold, including rank 0. upd_en is ignored while stalled.
- Branch kill on entry: if br_redirect=1, lanes with index > br_lane are written as invalid, with pc, we, waddr and wdata zeroed. Lane br_lane itself and all older lanes pass normally.
- Invalid lanes: in_valid=0 forces we=0 in rank 0; the other fields are captured as given.
- Update: on advance, lane i of rank UPD_STAGE+1 takes upd_wdata[i] if upd_en[i]=1, otherwise rank UPD_STAGE wdata. Only wdata is substituted; valid and we pass unchanged.
- Forwarding:
  - A match requires valid & we & (waddr==fwd_raddr) & (fwd_raddr≠0).
  - Priority runs from rank 0 (youngest) to rank STAGES-1. Within a rank, the higher lane wins.
  - Lookup is purely combinational on registered state. It does not see the current inputs.

## Timing
- Input presented in cycle t (advance) appears on rank 0 outputs in cycle t+1 and on rank k in cycle t+1+k, plus one cycle per stalled cycle in between.
- flush asserted in cycle t: all ranks are invalid in cycle t+1, regardless of stall.
- rst asserted mid-operation: outputs clear immediately (asynchronously) and stay 0 until the first edge after rst deasserts.
- br_redirect is sampled only on advance cycles.
- fwd outputs have zero latency relative to fwd_raddr.

## Structure
- Package pipe_pkg holds:
  - the lane-kill mask function kill_mask(br_redirect, br_lane, LANES), which returns the bitmask of surviving lanes;
  - the forwarding-priority encoder function;
  - the default-width localparams.
- Sub-module pipe_rank: one rank of LANES entries with async reset, sync clear, hold, per-lane kill mask, and per-lane wdata override. The top instantiates STAGES copies and the forwarding network.

## Test plan
- Advance: lane0 pc=0x1000 we=1 waddr=3 wdata=0xAA. Two cycles later stg_* of rank 1 shows the same values with valid=1.
- Branch kill, LANES=4: br_redirect=1, br_lane=1 with all in_valid=1. Rank 0 shows valid=4'b0011 and lanes 2–3 have all fields 0.
- Stall then flush: stall held for 3 cycles leaves ranks unchanged. flush=1 together with stall=1 gives all valid=0 on the next cycle.
- Update: upd_en[1]=1, upd_wdata=0x55 while rank 0 lane1 wdata=0x11. Rank 1 lane1 shows wdata=0x55 and the other lanes are unchanged.
- Forwarding priority:
  - rank1 lane0 writes r5=0x1 and rank0 lane0 writes r5=0x2: fwd_raddr=5 gives hit=1, data=0x2.
  - Adding rank0 lane1 r5=0x3 gives data=0x3.
  - fwd_raddr=0 gives hit=0.
- Async reset: rst pulsed between clock edges mid-stream. All outputs read 0 before the next edge.
